// File: rtl/apb_cmd_master.sv
// Single-outstanding command-to-APB bridge: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered.
// Optional ACCESS timeout abort is enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
    logic       tmo_hit;

    // Counter holds the number of PREADY-low ACCESS cycles already elapsed.
    assign tmo_hit = (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rdata_d     = rdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = SETUP;
                    paddr_d     = req_addr;
                    pwdata_d    = req_wdata;
                    pwrite_d    = req_write;
                    psel_d      = 1'b1;
                    req_ready_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                tmo_d     = 8'd0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = pwrite_q ? '0 : PRDATA;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                end else begin
                    tmo_d       = tmo_q + 8'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rdata_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rdata_q     <= rdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
